decode_ctrl_pipe: RTL
=====================

Name: decode_ctrl_pipe

Overview:
Registered, handshaked successor to the combinational control decoder. It accepts fetched 32-bit A64 instructions and decodes them into the datapath control bundle. It registers the bundle into a one-entry ID/EX output stage and supports 32-bit and 64-bit mode, MOVZ/MOVK halfword shift and LDP/STP splitting into two micro-ops. It sits between fetch and execute and honours execute back-pressure and branch flush.

Parameters:
ALUOP_W, 2, width of alu_op.
SUPPORT_W32, 1, 1: sf=0 encodings decode normally with w32=1; 0: sf=0 encodings are illegal.
SUPPORT_PAIR, 1, 1: LDP/STP split into two micro-ops; 0: LDP/STP are illegal.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous kill of held and in-progress work.
in_valid  in  1  instruction valid.
in_ready  out  1  decoder can accept.
instr  in  32  instruction word.
out_valid  out  1  bundle valid.
out_ready  in  1  execute accepts bundle.
uncond_branch  out  1  B.
flag_branch  out  1  B.cond.
zero_branch  out  1  CBZ.
mem_read  out  1  load.
mem_to_reg  out  1  writeback from memory.
mem_write  out  1  store.
flag_write  out  1  SUBS.
alu_src  out  1  immediate operand.
alu_op  out  ALUOP_W  00 add(addr), 01 pass-B(branch compare), 10 R-type.
reg_write  out  1  writes Rd/Rt.
mov_wide  out  1  MOVZ/MOVK.
mov_keep  out  1  MOVK (merge with old Rd).
hw_shift  out  2  instr[22:21] for move-wide, else 0.
w32  out  1  sf=0 op.
uop_idx  out  1  0 first/only, 1 second pair micro-op.
illegal  out  1  undecodable; all other control bits 0.

Behaviour:
- Reset (rst_n low, async): out_valid=0, all control outputs 0, state=RUN. in_ready follows its combinational equation.
- in_ready = (state==RUN) && (!out_valid || out_ready). It is combinational.
- Accept when in_valid && in_ready. The bundle appears on outputs the next cycle with out_valid=1. Latency is 1. Throughput is 1 per cycle.
- Outputs are held stable while out_valid && !out_ready.
- When out_valid && out_ready and there is no accept and the state is RUN, out_valid goes to 0 next cycle.
- Decode uses sf = instr[31] and is checked in this priority order:
  - NOP 0xD503201F: all 0. out_valid still pulses.
  - MOVZ [30:23]=10100101: reg_write, mov_wide, alu_src.
  - MOVK [30:23]=11100101: reg_write, mov_wide, mov_keep, alu_src.
  - For MOVZ/MOVK, hw_shift=instr[22:21]. sf=0 with hw[1]=1 is illegal.
  - ADD reg [30:24]=0001011 and SUB reg [30:24]=1001011: reg_write, alu_op=10.
  - SUBS reg [30:24]=1101011: same as SUB reg plus flag_write.
  - ADD imm [30:23]=00100010: reg_write, alu_src, alu_op=10.
  - LDUR [31:21]=11111000010: mem_read, mem_to_reg, reg_write, alu_src, alu_op=00.
  - STUR 11111000000: mem_write, alu_src, alu_op=00.
  - B [31:26]=000101: uncond_branch.
  - CBZ [30:24]=0110100: zero_branch, alu_op=01.
  - B.cond [31:24]=01010100: flag_branch.
  - LDP [31:22]=1010100101: LDUR bundle.
  - STP [31:22]=1010100100: STUR bundle.
  - Anything else: illegal=1.
- w32 = ~sf for sf-bearing ops, 0 otherwise. When SUPPORT_W32=0, sf=0 on sf-bearing ops is illegal.
- Pair FSM states: RUN and PAIR2.
  - LDP/STP accepted: emit uop_idx=0, latch the bundle in a side register, state goes RUN to PAIR2.
  - In PAIR2, in_ready=0. When the uop0 bundle handshakes, load the same bundle with uop_idx=1 and state goes to RUN.
  - The uop1 bundle then follows normal handshake rules.
- Illegal instructions still produce out_valid=1 with illegal=1. Execute decides trap handling.
- flush (synchronous) dominates all other actions: out_valid goes to 0 and state goes to RUN.
  - A handshake on a flush cycle still completes for the consumer. Input presented on a flush cycle is not accepted, because in_ready is forced to 0 while flush=1.
- Reset asserted mid-pair abandons uop1 immediately.
- Simultaneous out_ready and new accept in RUN: the new bundle replaces the old with no bubble.

Test Plan:
- Reset mid-stream: rst_n low while out_valid=1 -> out_valid=0 and all controls 0 immediately (async, before next edge).
- MOVK 0xF2A00000 (hw=01), out_ready=1 -> next cycle out_valid=1, reg_write=1, mov_keep=1, hw_shift=01, w32=0. Then 32-bit MOVZ hw=10 (0x52C00000) -> illegal=1.
- Back-pressure: stream LDUR 0xF8400020 then SUBS 0xEB020020, out_ready=0 for 3 cycles -> LDUR bundle held stable and in_ready=0; after release, SUBS bundle has flag_write=1 and alu_op=10 with no lost or duplicate bundle.
- LDP 0xA9400420 with out_ready=1 -> two consecutive bundles (mem_read=1, uop_idx 0 then 1) and in_ready=0 for exactly one cycle. With SUPPORT_PAIR=0 -> one bundle with illegal=1.
- Flush in PAIR2 with out_ready=0 -> next cycle out_valid=0, state RUN, in_ready=1, and no uop1 emitted.
- Full-throughput sequence of ADD imm, B, CBZ, B.cond, NOP with out_ready=1 -> one bundle per cycle:
  - ADD imm: alu_src and alu_op=10.
  - B: uncond_branch.
  - CBZ: zero_branch and alu_op=01.
  - B.cond: flag_branch.
  - NOP: all control bits 0, out_valid=1.

Source files
------------

// File: rtl/decode_ctrl_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the registered A64 control decoder.
// The decoder takes the slave modport; the fetch/execute environment takes the master.
interface decode_ctrl_pipe_if #(
    parameter int ALUOP_W = 2
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        instr;
    logic               out_valid;
    logic               out_ready;
    logic               uncond_branch;
    logic               flag_branch;
    logic               zero_branch;
    logic               mem_read;
    logic               mem_to_reg;
    logic               mem_write;
    logic               flag_write;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_write;
    logic               mov_wide;
    logic               mov_keep;
    logic [1:0]         hw_shift;
    logic               w32;
    logic               uop_idx;
    logic               illegal;

    modport master (
        output flush, in_valid, instr, out_ready,
        input  in_ready, out_valid,
        input  uncond_branch, flag_branch, zero_branch, mem_read, mem_to_reg,
        input  mem_write, flag_write, alu_src, alu_op, reg_write, mov_wide,
        input  mov_keep, hw_shift, w32, uop_idx, illegal
    );

    modport slave (
        input  flush, in_valid, instr, out_ready,
        output in_ready, out_valid,
        output uncond_branch, flag_branch, zero_branch, mem_read, mem_to_reg,
        output mem_write, flag_write, alu_src, alu_op, reg_write, mov_wide,
        output mov_keep, hw_shift, w32, uop_idx, illegal
    );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// Registered A64 control decoder with a one-entry ID/EX output stage.
// LDP/STP are split into two micro-ops through a side register and a RUN/PAIR2 FSM.
module decode_ctrl_pipe #(
    parameter int ALUOP_W      = 2,
    parameter bit SUPPORT_W32  = 1'b1,
    parameter bit SUPPORT_PAIR = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    decode_ctrl_pipe_if.slave bus
);

    localparam logic [31:0] NOP_WORD = 32'hD503_201F;

    typedef struct packed {
        logic               uncondBranch;
        logic               flagBranch;
        logic               zeroBranch;
        logic               memRead;
        logic               memToReg;
        logic               memWrite;
        logic               flagWrite;
        logic               aluSrc;
        logic [ALUOP_W-1:0] aluOp;
        logic               regWrite;
        logic               movWide;
        logic               movKeep;
        logic [1:0]         hwShift;
        logic               w32;
        logic               uopIdx;
        logic               illegal;
    } ctrl_t;

    typedef enum logic {
        RUN   = 1'b0,
        PAIR2 = 1'b1
    } state_e;

    state_e state_q, state_d;
    ctrl_t  bundle_q, bundle_d;
    ctrl_t  side_q, side_d;
    logic   outValid_q, outValid_d;

    ctrl_t  dec;
    logic   decPair;
    logic   sfOp;
    logic   bad;
    logic   sf;
    logic   accept;
    logic   handshake;

    function automatic ctrl_t memBundle(input logic load);
        ctrl_t c;
        c          = '0;
        c.aluSrc   = 1'b1;
        c.aluOp    = ALUOP_W'(0);
        c.memRead  = load;
        c.memToReg = load;
        c.regWrite = load;
        c.memWrite = !load;
        return c;
    endfunction

    assign sf        = bus.instr[31];
    assign accept    = bus.in_valid && bus.in_ready;
    assign handshake = outValid_q && bus.out_ready;

    // Priority decode; bit 29 splits MOVZ/MOVK and SUBS from ADD/SUB, bit 22 splits load from store.
    always_comb begin
        dec     = '0;
        decPair = 1'b0;
        sfOp    = 1'b0;
        bad     = 1'b0;
        if (bus.instr == NOP_WORD) begin
            dec = '0;
        end else if (bus.instr[30:23] == 8'b10100101 || bus.instr[30:23] == 8'b11100101) begin
            sfOp         = 1'b1;
            dec.regWrite = 1'b1;
            dec.movWide  = 1'b1;
            dec.aluSrc   = 1'b1;
            dec.movKeep  = bus.instr[29];
            dec.hwShift  = bus.instr[22:21];
            bad          = !sf && bus.instr[22];
        end else if (bus.instr[30:24] == 7'b0001011 || bus.instr[30:24] == 7'b1001011 ||
                     bus.instr[30:24] == 7'b1101011) begin
            sfOp          = 1'b1;
            dec.regWrite  = 1'b1;
            dec.aluOp     = ALUOP_W'(2);
            dec.flagWrite = bus.instr[29];
        end else if (bus.instr[30:23] == 8'b00100010) begin
            sfOp         = 1'b1;
            dec.regWrite = 1'b1;
            dec.aluSrc   = 1'b1;
            dec.aluOp    = ALUOP_W'(2);
        end else if (bus.instr[31:23] == 9'b111110000 && !bus.instr[21]) begin
            dec = memBundle(bus.instr[22]);
        end else if (bus.instr[31:26] == 6'b000101) begin
            dec.uncondBranch = 1'b1;
        end else if (bus.instr[30:24] == 7'b0110100) begin
            sfOp           = 1'b1;
            dec.zeroBranch = 1'b1;
            dec.aluOp      = ALUOP_W'(1);
        end else if (bus.instr[31:24] == 8'b01010100) begin
            dec.flagBranch = 1'b1;
        end else if (bus.instr[31:23] == 9'b101010010) begin
            dec     = memBundle(bus.instr[22]);
            decPair = SUPPORT_PAIR;
            bad     = !SUPPORT_PAIR;
        end else begin
            bad = 1'b1;
        end

        if (sfOp) begin
            dec.w32 = !sf;
            if (!sf && !SUPPORT_W32) begin
                bad = 1'b1;
            end
        end

        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
            decPair     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:   if (accept && decPair) state_d = PAIR2;
                PAIR2: if (handshake)         state_d = RUN;
            endcase
        end
    end

    always_comb begin
        bus.in_ready = (state_q == RUN) && (!outValid_q || bus.out_ready) && !bus.flush;
    end

    // The side register always holds the uop1 copy of the last accepted bundle; only PAIR2 uses it.
    always_comb begin
        outValid_d = outValid_q;
        bundle_d   = bundle_q;
        side_d     = side_q;
        if (bus.flush) begin
            outValid_d = 1'b0;
            bundle_d   = '0;
        end else if (accept) begin
            outValid_d    = 1'b1;
            bundle_d      = dec;
            side_d        = dec;
            side_d.uopIdx = 1'b1;
        end else if (state_q == PAIR2 && handshake) begin
            outValid_d = 1'b1;
            bundle_d   = side_q;
        end else if (handshake) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            bundle_q   <= '0;
            side_q     <= '0;
        end else begin
            outValid_q <= outValid_d;
            bundle_q   <= bundle_d;
            side_q     <= side_d;
        end
    end

    assign bus.out_valid     = outValid_q;
    assign bus.uncond_branch = bundle_q.uncondBranch;
    assign bus.flag_branch   = bundle_q.flagBranch;
    assign bus.zero_branch   = bundle_q.zeroBranch;
    assign bus.mem_read      = bundle_q.memRead;
    assign bus.mem_to_reg    = bundle_q.memToReg;
    assign bus.mem_write     = bundle_q.memWrite;
    assign bus.flag_write    = bundle_q.flagWrite;
    assign bus.alu_src       = bundle_q.aluSrc;
    assign bus.alu_op        = bundle_q.aluOp;
    assign bus.reg_write     = bundle_q.regWrite;
    assign bus.mov_wide      = bundle_q.movWide;
    assign bus.mov_keep      = bundle_q.movKeep;
    assign bus.hw_shift      = bundle_q.hwShift;
    assign bus.w32           = bundle_q.w32;
    assign bus.uop_idx       = bundle_q.uopIdx;
    assign bus.illegal       = bundle_q.illegal;

endmodule
